// File: rtl/cache_pkg.sv
// Shared types and default geometry for the 2-way set-associative cache controller.
package cache_pkg;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_INDEX_W = 1;
    localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W;
    localparam int DEF_SETS    = 1 << DEF_INDEX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITEBACK,
        ST_REFILL,
        ST_DONE
    } state_t;

    // Invalid ways are filled before anything is evicted; otherwise LRU names the victim.
    function automatic logic pick_victim(input logic [1:0] valid, input logic lru);
        if (!valid[0]) return 1'b0;
        if (!valid[1]) return 1'b1;
        return lru;
    endfunction

endpackage

// File: rtl/cache2vias_array.sv
// Tag/valid/dirty/data store for both ways plus per-set LRU bit.
// Combinational read of the addressed set, single synchronous write port.
module cache2vias_array
    import cache_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int SETS    = DEF_SETS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [INDEX_W-1:0]          index,
    output logic [1:0]                  rd_valid,
    output logic [1:0]                  rd_dirty,
    output logic [1:0][TAG_W-1:0]       rd_tag,
    output logic [1:0][DATA_W-1:0]      rd_data,
    output logic                        rd_lru,
    input  logic                        wr_en,
    input  logic                        wr_way,
    input  logic                        wr_dirty,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        lru_we,
    input  logic                        lru_val
);

    logic [SETS-1:0][1:0]              valid_q, valid_d;
    logic [SETS-1:0][1:0]              dirty_q, dirty_d;
    logic [SETS-1:0][1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [SETS-1:0][1:0][DATA_W-1:0]  data_q, data_d;
    logic [SETS-1:0]                   lru_q, lru_d;

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];
    assign rd_lru   = lru_q[index];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        lru_d   = lru_q;
        if (wr_en) begin
            valid_d[index][wr_way] = 1'b1;
            dirty_d[index][wr_way] = wr_dirty;
            tag_d[index][wr_way]   = wr_tag;
            data_d[index][wr_way]  = wr_data;
        end
        if (lru_we) begin
            lru_d[index] = lru_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            lru_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            lru_q   <= lru_d;
        end
    end

endmodule

// File: rtl/controlador_cache2vias.sv
// Write-back, write-allocate controller for a 2-way set-associative cache.
// state     | meaning
// IDLE      | ready for a CPU access
// COMPARE   | tag lookup; hit performs the access, miss picks a victim
// WRITEBACK | dirty victim being written to memory
// REFILL    | missing line being read from memory into the victim way
// DONE      | access complete; counters and CPU result updated
module controlador_cache2vias
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                replay_q, replay_d;
    logic                victim_q, victim_d;
    logic [DATA_W-1:0]   rdata_lat_q, rdata_lat_d;
    logic                cpu_done_q, cpu_done_d;
    logic                cpu_hit_q, cpu_hit_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]          hit_count_q, hit_count_d;
    logic [7:0]          miss_count_q, miss_count_d;

    logic [1:0]                 arr_valid, arr_dirty;
    logic [1:0][TAG_W-1:0]      arr_tag;
    logic [1:0][DATA_W-1:0]     arr_data;
    logic                       arr_lru;
    logic                       wr_en, wr_way, wr_dirty, lru_we, lru_val;
    logic [DATA_W-1:0]          wr_data;

    logic [INDEX_W-1:0] lk_index;
    logic [TAG_W-1:0]   lk_tag;
    logic               hit0, hit1, hit, hit_way, victim_sel, mem_xfer;

    assign lk_index   = addr_q[INDEX_W-1:0];
    assign lk_tag     = addr_q[ADDR_W-1:INDEX_W];
    assign hit0       = arr_valid[0] && (arr_tag[0] == lk_tag);
    assign hit1       = arr_valid[1] && (arr_tag[1] == lk_tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;
    assign victim_sel = pick_victim(arr_valid, arr_lru);
    assign mem_xfer   = mem_req_q && mem_ack;

    cache2vias_array #(
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .SETS    (SETS)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .index    (lk_index),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .rd_lru   (arr_lru),
        .wr_en    (wr_en),
        .wr_way   (wr_way),
        .wr_dirty (wr_dirty),
        .wr_tag   (lk_tag),
        .wr_data  (wr_data),
        .lru_we   (lru_we),
        .lru_val  (lru_val)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        replay_d     = replay_q;
        victim_d     = victim_q;
        rdata_lat_d  = rdata_lat_q;
        cpu_hit_d    = cpu_hit_q;
        cpu_rdata_d  = cpu_rdata_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wr_en        = 1'b0;
        wr_way       = 1'b0;
        wr_dirty     = 1'b0;
        wr_data      = wdata_q;
        lru_we       = 1'b0;
        lru_val      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_d     = cpu_we;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    replay_d = 1'b0;
                    state_d  = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (hit) begin
                    lru_we  = 1'b1;
                    lru_val = ~hit_way;
                    if (we_q) begin
                        wr_en    = 1'b1;
                        wr_way   = hit_way;
                        wr_dirty = 1'b1;
                    end else begin
                        rdata_lat_d = arr_data[hit_way];
                    end
                    state_d = ST_DONE;
                end else begin
                    victim_d = victim_sel;
                    replay_d = 1'b1;
                    state_d  = (arr_valid[victim_sel] && arr_dirty[victim_sel])
                               ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (mem_xfer) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                if (mem_xfer) begin
                    wr_en    = 1'b1;
                    wr_way   = victim_q;
                    wr_dirty = 1'b0;
                    wr_data  = mem_rdata;
                    state_d  = ST_COMPARE;
                end
            end
            ST_DONE: begin
                cpu_hit_d = ~replay_q;
                if (!we_q) cpu_rdata_d = rdata_lat_q;
                if (replay_q) miss_count_d = miss_count_q + 8'd1;
                else          hit_count_d  = hit_count_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cpu_done_d = (state_q == ST_DONE);

        // Request drops on the ack edge, so back-to-back write-back/refill leaves one idle cycle.
        mem_req_d = ((state_d == ST_WRITEBACK) || (state_d == ST_REFILL)) && !mem_xfer;
        if (mem_req_d && !mem_req_q) begin
            if (state_d == ST_WRITEBACK) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {arr_tag[victim_sel], lk_index};
                mem_wdata_d = arr_data[victim_sel];
            end else begin
                mem_we_d   = 1'b0;
                mem_addr_d = addr_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            replay_q     <= 1'b0;
            victim_q     <= 1'b0;
            rdata_lat_q  <= '0;
            cpu_done_q   <= 1'b0;
            cpu_hit_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            replay_q     <= replay_d;
            victim_q     <= victim_d;
            rdata_lat_q  <= rdata_lat_d;
            cpu_done_q   <= cpu_done_d;
            cpu_hit_q    <= cpu_hit_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign cpu_ready  = (state_q == ST_IDLE);
    assign cpu_done   = cpu_done_q;
    assign cpu_hit    = cpu_hit_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_controlador_cache2vias.sv
// Directed bench for controlador_cache2vias with an inline variable-latency memory responder.
module tb_controlador_cache2vias;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready, cpu_done, cpu_hit;
    logic [7:0] cpu_rdata;
    logic       mem_req, mem_we, mem_ack;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] hit_count, miss_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] memory [32];

    int         r_cyc, r_wb, r_rf;
    logic [4:0] r_wb_addr, r_rf_addr;
    logic [7:0] r_wb_data;
    logic       r_first_we, r_done;

    always #5 clk = ~clk;

    controlador_cache2vias dut (
        .clock      (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .cpu_hit    (cpu_hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One CPU access; acts as memory with ack 'lat' cycles after mem_req rises.
    task automatic access(input logic we, input logic [4:0] addr, input logic [7:0] wd, input int lat);
        bit prev_req;
        int cnt;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        r_cyc = 0; r_wb = 0; r_rf = 0; r_first_we = 1'b0; r_done = 1'b0;
        r_wb_addr = '0; r_wb_data = '0; r_rf_addr = '0;
        prev_req = 1'b0; cnt = 0;
        while (!r_done && r_cyc < 200) begin
            @(negedge clk);
            r_cyc++;
            if (r_cyc == 1) cpu_req = 1'b0;
            mem_ack = 1'b0;
            if (mem_req) begin
                cnt = prev_req ? cnt + 1 : 1;
                if (cnt == lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        r_wb++;
                        r_wb_addr = mem_addr;
                        r_wb_data = mem_wdata;
                        if (r_wb + r_rf == 1) r_first_we = 1'b1;
                        memory[mem_addr] = mem_wdata;
                    end else begin
                        r_rf++;
                        r_rf_addr = mem_addr;
                        mem_rdata = memory[mem_addr];
                    end
                end
            end
            prev_req = mem_req;
            if (cpu_done) r_done = 1'b1;
        end
        mem_ack = 1'b0;
        chk("access_completes", r_done, 1'b1);
    endtask

    initial begin
        int nonhit, mem_seen, acc, dones, dbl, k;
        logic prev_done, seen_wb;
        for (int i = 0; i < 32; i++) memory[i] = 8'(i) ^ 8'hA5;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_ready", cpu_ready, 1'b1);
        chk("rst_done", cpu_done, 1'b0);
        chk("rst_hit", cpu_hit, 1'b0);
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 5'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_counts", {hit_count, miss_count}, 16'h0000);
        reset = 1'b0;

        // cold read miss, clean victim
        access(1'b0, 5'h05, 8'h00, 3);
        chk("rd05_cycles", r_cyc, 7);
        chk("rd05_refills", r_rf, 1);
        chk("rd05_wbs", r_wb, 0);
        chk("rd05_rf_addr", r_rf_addr, 5'h05);
        chk("rd05_rdata", cpu_rdata, 8'hA0);
        chk("rd05_hit", cpu_hit, 1'b0);
        chk("rd05_miss_cnt", miss_count, 8'd1);

        access(1'b0, 5'h05, 8'h00, 3);
        chk("rd05b_cycles", r_cyc, 3);
        chk("rd05b_nomem", r_rf + r_wb, 0);
        chk("rd05b_rdata", cpu_rdata, 8'hA0);
        chk("rd05b_hit", cpu_hit, 1'b1);
        chk("rd05b_hit_cnt", hit_count, 8'd1);

        access(1'b1, 5'h05, 8'h3C, 3);
        chk("wr05_cycles", r_cyc, 3);
        chk("wr05_hit", cpu_hit, 1'b1);
        chk("wr05_rdata_held", cpu_rdata, 8'hA0);
        chk("wr05_hit_cnt", hit_count, 8'd2);

        access(1'b0, 5'h07, 8'h00, 3);
        chk("rd07_cycles", r_cyc, 7);
        chk("rd07_wbs", r_wb, 0);
        chk("rd07_rdata", cpu_rdata, 8'hA2);

        // set 1 full, LRU points at dirty 0x05
        access(1'b0, 5'h09, 8'h00, 2);
        chk("rd09_cycles", r_cyc, 9);
        chk("rd09_wbs", r_wb, 1);
        chk("rd09_wb_first", r_first_we, 1'b1);
        chk("rd09_wb_addr", r_wb_addr, 5'h05);
        chk("rd09_wb_data", r_wb_data, 8'h3C);
        chk("rd09_refills", r_rf, 1);
        chk("rd09_rf_addr", r_rf_addr, 5'h09);
        chk("rd09_rdata", cpu_rdata, 8'hAC);
        chk("rd09_hit", cpu_hit, 1'b0);
        chk("rd09_counts", {hit_count, miss_count}, {8'd2, 8'd3});

        // LRU in set 0
        access(1'b0, 5'h02, 8'h00, 1);
        chk("rd02_cycles", r_cyc, 5);
        access(1'b0, 5'h04, 8'h00, 1);
        chk("rd04_rdata", cpu_rdata, 8'hA1);
        access(1'b0, 5'h02, 8'h00, 1);
        chk("rd02b_hit", cpu_hit, 1'b1);
        access(1'b0, 5'h06, 8'h00, 1);
        chk("rd06_wbs", r_wb, 0);
        chk("rd06_rf_addr", r_rf_addr, 5'h06);
        chk("rd06_rdata", cpu_rdata, 8'hA3);
        access(1'b0, 5'h02, 8'h00, 1);
        chk("rd02c_hit", cpu_hit, 1'b1);
        chk("rd02c_nomem", r_rf + r_wb, 0);
        chk("rd02c_rdata", cpu_rdata, 8'hA7);
        chk("lru_counts", {hit_count, miss_count}, {8'd4, 8'd6});

        // dirty both ways of set 0, then reset in the middle of a write-back
        access(1'b1, 5'h02, 8'h55, 1);
        access(1'b1, 5'h06, 8'h66, 1);
        chk("dirty_hits", hit_count, 8'd6);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h08;
        seen_wb = 1'b0;
        for (int i = 0; i < 20 && !seen_wb; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (mem_req && mem_we) seen_wb = 1'b1;
        end
        chk("wb_started", seen_wb, 1'b1);
        chk("wb_addr", mem_addr, 5'h02);
        chk("wb_data", mem_wdata, 8'h55);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstwb_mem_req", mem_req, 1'b0);
        chk("rstwb_ready", cpu_ready, 1'b1);
        chk("rstwb_counts", {hit_count, miss_count}, 16'h0000);
        reset = 1'b0;

        access(1'b0, 5'h02, 8'h00, 1);
        chk("post_rst_hit", cpu_hit, 1'b0);
        chk("post_rst_rdata", cpu_rdata, 8'hA7);
        chk("post_rst_miss_cnt", miss_count, 8'd1);

        // hit counter wrap
        nonhit = 0; mem_seen = 0;
        for (int i = 0; i < 256; i++) begin
            access(1'b0, 5'h02, 8'h00, 1);
            if (cpu_hit !== 1'b1) nonhit++;
            mem_seen += r_rf + r_wb;
            if (i == 254) chk("wrap_255", hit_count, 8'd255);
        end
        chk("wrap_nonhits", nonhit, 0);
        chk("wrap_nomem", mem_seen, 0);
        chk("wrap_hit_cnt", hit_count, 8'd0);
        chk("wrap_miss_cnt", miss_count, 8'd1);

        // cpu_req held high across ten accesses
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h02;
        acc = 0; dones = 0; dbl = 0; k = 0; prev_done = 1'b0;
        while (k < 200) begin
            k++;
            if (cpu_done) begin
                dones++;
                if (prev_done) dbl++;
            end
            prev_done = cpu_done;
            if (cpu_ready) begin
                if (acc == 10) begin
                    cpu_req = 1'b0;
                    break;
                end
                acc++;
            end
            @(negedge clk);
        end
        chk("held_accepts", acc, 10);
        chk("held_done_pulses", dones, 10);
        chk("held_double_done", dbl, 0);
        chk("held_span", k, 31);
        chk("held_counts", {hit_count, miss_count}, {8'd10, 8'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
